// File: rtl/multicycle_control.sv
// Control FSM for a multicycle MIPS-style datapath: sequences fetch, decode,
// execute, memory and write-back steps and drives the datapath control lines.
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [3:0] state,
  output logic       pc_write,
  output logic       ir_write,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic       zero_imm,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [2:0] alu_op
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_IEXEC  = 4'd10,
    S_IWB    = 4'd11,
    S_JAL    = 4'd12
  } state_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ANDI = 6'h0c;
  localparam logic [5:0] OP_ORI  = 6'h0d;
  localparam logic [5:0] OP_LUI  = 6'h0f;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2b;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;

  localparam logic [2:0] ALU_AND   = 3'b000;
  localparam logic [2:0] ALU_OR    = 3'b001;
  localparam logic [2:0] ALU_ADD   = 3'b011;
  localparam logic [2:0] ALU_SUB   = 3'b100;
  localparam logic [2:0] ALU_LUI   = 3'b101;
  localparam logic [2:0] ALU_JAL   = 3'b110;
  localparam logic [2:0] ALU_FUNCT = 3'b111;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       alu_src_a;
    logic       zero_imm;
    logic       instr_done;
    logic       illegal_op;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [2:0] alu_op;
  } ctrl_t;

  state_t     state_q, state_d;
  ctrl_t      ctrl, ctrl_out;
  logic [2:0] imm_alu_op;
  logic       imm_zero_ext;
  logic       branch_taken;
  logic       legal_op;

  always_comb begin
    imm_alu_op   = ALU_ADD;
    imm_zero_ext = 1'b0;
    case (op)
      OP_ANDI: begin imm_alu_op = ALU_AND; imm_zero_ext = 1'b1; end
      OP_ORI:  begin imm_alu_op = ALU_OR;  imm_zero_ext = 1'b1; end
      OP_LUI:  imm_alu_op = ALU_LUI;
      default: imm_alu_op = ALU_ADD;
    endcase
  end

  always_comb begin
    case (op)
      OP_R, OP_ADDI, OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_SW,
      OP_BEQ, OP_BNE, OP_J, OP_JAL: legal_op = 1'b1;
      default:                      legal_op = 1'b0;
    endcase
  end

  assign branch_taken = ((op == OP_BEQ) && zero) || ((op == OP_BNE) && !zero);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW:                      state_d = S_MEMADR;
          OP_R:                              state_d = S_EXEC;
          OP_ADDI, OP_ANDI, OP_ORI, OP_LUI:  state_d = S_IEXEC;
          OP_BEQ, OP_BNE:                    state_d = S_BRANCH;
          OP_J:                              state_d = S_JUMP;
          OP_JAL:                            state_d = S_JAL;
          default:                           state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_ALUWB;
      S_IEXEC:  state_d = S_IWB;
      default:  state_d = S_FETCH;
    endcase
  end

  // Output logic; undefined state codes fall through to all-zero
  always_comb begin
    ctrl = '0;
    case (state_q)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = 2'b01;
        ctrl.alu_op    = ALU_ADD;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b  = 2'b11;
        ctrl.alu_op     = ALU_ADD;
        ctrl.illegal_op = !legal_op;
        ctrl.instr_done = !legal_op;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 2'b01;
        ctrl.instr_done = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write  = 1'b1;
        ctrl.iord       = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 2'b01;
        ctrl.instr_done = 1'b1;
      end
      S_IEXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        ctrl.alu_op    = imm_alu_op;
        ctrl.zero_imm  = imm_zero_ext;
      end
      S_IWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.alu_op     = imm_alu_op;
        ctrl.zero_imm   = imm_zero_ext;
        ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_op     = ALU_SUB;
        ctrl.pc_src     = 2'b01;
        ctrl.pc_write   = branch_taken;
        ctrl.instr_done = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_src     = 2'b10;
        ctrl.pc_write   = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_JAL: begin
        ctrl.pc_src     = 2'b10;
        ctrl.pc_write   = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 2'b10;
        ctrl.mem_to_reg = 2'b10;
        ctrl.alu_op     = ALU_JAL;
        ctrl.instr_done = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

  // Reset masks every strobe combinationally so an in-flight instruction cannot commit
  assign ctrl_out = reset ? '0 : ctrl;

  assign state      = state_q;
  assign pc_write   = ctrl_out.pc_write;
  assign ir_write   = ctrl_out.ir_write;
  assign iord       = ctrl_out.iord;
  assign mem_read   = ctrl_out.mem_read;
  assign mem_write  = ctrl_out.mem_write;
  assign reg_write  = ctrl_out.reg_write;
  assign alu_src_a  = ctrl_out.alu_src_a;
  assign zero_imm   = ctrl_out.zero_imm;
  assign instr_done = ctrl_out.instr_done;
  assign illegal_op = ctrl_out.illegal_op;
  assign reg_dst    = ctrl_out.reg_dst;
  assign mem_to_reg = ctrl_out.mem_to_reg;
  assign alu_src_b  = ctrl_out.alu_src_b;
  assign pc_src     = ctrl_out.pc_src;
  assign alu_op     = ctrl_out.alu_op;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed, table-driven bench for multicycle_control: each row gives the
// inputs for one cycle and the state and control outputs expected in that cycle.
module tb_multicycle_control;

  typedef struct packed {
    logic       pcw;
    logic       irw;
    logic       iord;
    logic       mrd;
    logic       mwr;
    logic       rgw;
    logic       asa;
    logic       zimm;
    logic       done;
    logic       ill;
    logic [1:0] rdst;
    logic [1:0] m2r;
    logic [1:0] asb;
    logic [1:0] psrc;
    logic [2:0] aop;
  } outs_t;

  typedef struct {
    logic       rst;
    logic [5:0] op;
    logic       z;
    logic       mr;
    logic [3:0] st;
    outs_t      o;
  } vec_t;

  localparam outs_t O_ZERO     = '0;
  localparam outs_t O_FETCH    = '{pcw:1'b1, irw:1'b1, mrd:1'b1, asb:2'b01, aop:3'b011, default:'0};
  localparam outs_t O_FETCH_W  = '{mrd:1'b1, asb:2'b01, aop:3'b011, default:'0};
  localparam outs_t O_DEC      = '{asb:2'b11, aop:3'b011, default:'0};
  localparam outs_t O_DEC_ILL  = '{done:1'b1, ill:1'b1, asb:2'b11, aop:3'b011, default:'0};
  localparam outs_t O_MADR     = '{asa:1'b1, asb:2'b10, aop:3'b011, default:'0};
  localparam outs_t O_MRD      = '{mrd:1'b1, iord:1'b1, default:'0};
  localparam outs_t O_MWB      = '{rgw:1'b1, m2r:2'b01, done:1'b1, default:'0};
  localparam outs_t O_MWR      = '{mwr:1'b1, iord:1'b1, default:'0};
  localparam outs_t O_MWR_DONE = '{mwr:1'b1, iord:1'b1, done:1'b1, default:'0};
  localparam outs_t O_EXEC     = '{asa:1'b1, aop:3'b111, default:'0};
  localparam outs_t O_ALUWB    = '{rgw:1'b1, rdst:2'b01, done:1'b1, default:'0};
  localparam outs_t O_BR_T     = '{pcw:1'b1, asa:1'b1, aop:3'b100, psrc:2'b01, done:1'b1, default:'0};
  localparam outs_t O_BR_N     = '{asa:1'b1, aop:3'b100, psrc:2'b01, done:1'b1, default:'0};
  localparam outs_t O_JUMP     = '{pcw:1'b1, psrc:2'b10, done:1'b1, default:'0};
  localparam outs_t O_JAL      = '{pcw:1'b1, psrc:2'b10, rgw:1'b1, rdst:2'b10, m2r:2'b10, aop:3'b110, done:1'b1, default:'0};
  localparam outs_t O_IEX_ADD  = '{asa:1'b1, asb:2'b10, aop:3'b011, default:'0};
  localparam outs_t O_IWB_ADD  = '{rgw:1'b1, aop:3'b011, done:1'b1, default:'0};
  localparam outs_t O_IEX_AND  = '{asa:1'b1, asb:2'b10, aop:3'b000, zimm:1'b1, default:'0};
  localparam outs_t O_IWB_AND  = '{rgw:1'b1, aop:3'b000, zimm:1'b1, done:1'b1, default:'0};
  localparam outs_t O_IEX_OR   = '{asa:1'b1, asb:2'b10, aop:3'b001, zimm:1'b1, default:'0};
  localparam outs_t O_IWB_OR   = '{rgw:1'b1, aop:3'b001, zimm:1'b1, done:1'b1, default:'0};
  localparam outs_t O_IEX_LUI  = '{asa:1'b1, asb:2'b10, aop:3'b101, default:'0};
  localparam outs_t O_IWB_LUI  = '{rgw:1'b1, aop:3'b101, done:1'b1, default:'0};

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic       zero;
  logic       mem_ready;
  logic [3:0] state;
  logic       pc_write, ir_write, iord, mem_read, mem_write, reg_write;
  logic       alu_src_a, zero_imm, instr_done, illegal_op;
  logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_src;
  logic [2:0] alu_op;

  int unsigned total = 0;
  int unsigned bad   = 0;
  vec_t        vecs[$];

  multicycle_control dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .state      (state),
    .pc_write   (pc_write),
    .ir_write   (ir_write),
    .iord       (iord),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .zero_imm   (zero_imm),
    .instr_done (instr_done),
    .illegal_op (illegal_op),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_src_b  (alu_src_b),
    .pc_src     (pc_src),
    .alu_op     (alu_op)
  );

  always #5 clk = ~clk;

  task automatic add(input logic r, input logic [5:0] o, input logic z, input logic m,
                     input logic [3:0] s, input outs_t e);
    vec_t v;
    v.rst = r; v.op = o; v.z = z; v.mr = m; v.st = s; v.o = e;
    vecs.push_back(v);
  endtask

  // Drives one cycle's inputs, checks the cycle's outputs, then advances past the edge
  task automatic step(input string name, input logic r, input logic [5:0] o, input logic z,
                      input logic m, input logic [3:0] s, input outs_t e);
    outs_t act;
    reset = r; op = o; zero = z; mem_ready = m;
    #1;
    act = '{pcw:pc_write, irw:ir_write, iord:iord, mrd:mem_read, mwr:mem_write, rgw:reg_write,
            asa:alu_src_a, zimm:zero_imm, done:instr_done, ill:illegal_op, rdst:reg_dst,
            m2r:mem_to_reg, asb:alu_src_b, psrc:pc_src, aop:alu_op};
    total++;
    if (state !== s || act !== e) begin
      bad++;
      $display("FAIL %s: got state=%0d outs=%06h, want state=%0d outs=%06h", name, state, act, s, e);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; op = 6'h00; zero = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    #1;

    add(1, 6'h00, 0, 1, 0, O_ZERO);
    // LW, no waits: 0,1,2,3,4
    add(0, 6'h23, 0, 1, 0, O_FETCH);
    add(0, 6'h23, 0, 1, 1, O_DEC);
    add(0, 6'h23, 0, 1, 2, O_MADR);
    add(0, 6'h23, 0, 1, 3, O_MRD);
    add(0, 6'h23, 0, 1, 4, O_MWB);
    // SW with three wait cycles in MEMWR
    add(0, 6'h2b, 0, 1, 0, O_FETCH);
    add(0, 6'h2b, 0, 1, 1, O_DEC);
    add(0, 6'h2b, 0, 1, 2, O_MADR);
    add(0, 6'h2b, 0, 0, 5, O_MWR);
    add(0, 6'h2b, 0, 0, 5, O_MWR);
    add(0, 6'h2b, 0, 0, 5, O_MWR);
    add(0, 6'h2b, 0, 1, 5, O_MWR_DONE);
    // R-type
    add(0, 6'h00, 0, 1, 0, O_FETCH);
    add(0, 6'h00, 0, 1, 1, O_DEC);
    add(0, 6'h00, 0, 1, 6, O_EXEC);
    add(0, 6'h00, 0, 1, 7, O_ALUWB);
    // BEQ taken / not taken, BNE not taken / taken
    add(0, 6'h04, 1, 1, 0, O_FETCH);
    add(0, 6'h04, 1, 1, 1, O_DEC);
    add(0, 6'h04, 1, 1, 8, O_BR_T);
    add(0, 6'h04, 0, 1, 0, O_FETCH);
    add(0, 6'h04, 0, 1, 1, O_DEC);
    add(0, 6'h04, 0, 1, 8, O_BR_N);
    add(0, 6'h05, 1, 1, 0, O_FETCH);
    add(0, 6'h05, 1, 1, 1, O_DEC);
    add(0, 6'h05, 1, 1, 8, O_BR_N);
    add(0, 6'h05, 0, 1, 0, O_FETCH);
    add(0, 6'h05, 0, 1, 1, O_DEC);
    add(0, 6'h05, 0, 1, 8, O_BR_T);
    // ORI
    add(0, 6'h0d, 0, 1, 0, O_FETCH);
    add(0, 6'h0d, 0, 1, 1, O_DEC);
    add(0, 6'h0d, 0, 1, 10, O_IEX_OR);
    add(0, 6'h0d, 0, 1, 11, O_IWB_OR);
    // JAL, J
    add(0, 6'h03, 0, 1, 0, O_FETCH);
    add(0, 6'h03, 0, 1, 1, O_DEC);
    add(0, 6'h03, 0, 1, 12, O_JAL);
    add(0, 6'h02, 0, 1, 0, O_FETCH);
    add(0, 6'h02, 0, 1, 1, O_DEC);
    add(0, 6'h02, 0, 1, 9, O_JUMP);
    // Illegal opcode
    add(0, 6'h3f, 0, 1, 0, O_FETCH);
    add(0, 6'h3f, 0, 1, 1, O_DEC_ILL);
    // FETCH stalls for memory, then ADDI
    add(0, 6'h08, 0, 0, 0, O_FETCH_W);
    add(0, 6'h08, 0, 0, 0, O_FETCH_W);
    add(0, 6'h08, 0, 1, 0, O_FETCH);
    add(0, 6'h08, 0, 1, 1, O_DEC);
    add(0, 6'h08, 0, 1, 10, O_IEX_ADD);
    add(0, 6'h08, 0, 1, 11, O_IWB_ADD);
    // ANDI, LUI
    add(0, 6'h0c, 0, 1, 0, O_FETCH);
    add(0, 6'h0c, 0, 1, 1, O_DEC);
    add(0, 6'h0c, 0, 1, 10, O_IEX_AND);
    add(0, 6'h0c, 0, 1, 11, O_IWB_AND);
    add(0, 6'h0f, 0, 1, 0, O_FETCH);
    add(0, 6'h0f, 0, 1, 1, O_DEC);
    add(0, 6'h0f, 0, 1, 10, O_IEX_LUI);
    add(0, 6'h0f, 0, 1, 11, O_IWB_LUI);

    foreach (vecs[i])
      step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].op, vecs[i].z, vecs[i].mr, vecs[i].st, vecs[i].o);

    // Reset held two cycles while LW waits in MEMRD
    step("lw_fetch",      0, 6'h23, 0, 1, 0, O_FETCH);
    step("lw_dec",        0, 6'h23, 0, 1, 1, O_DEC);
    step("lw_madr",       0, 6'h23, 0, 1, 2, O_MADR);
    step("lw_memrd_wait", 0, 6'h23, 0, 0, 3, O_MRD);
    step("rst_in_memrd",  1, 6'h23, 0, 0, 3, O_ZERO);
    step("rst_second",    1, 6'h23, 0, 1, 0, O_ZERO);
    step("fetch_after",   0, 6'h23, 0, 1, 0, O_FETCH);
    step("lw2_dec",       0, 6'h23, 0, 1, 1, O_DEC);
    step("lw2_madr",      0, 6'h23, 0, 1, 2, O_MADR);
    step("lw2_memrd",     0, 6'h23, 0, 1, 3, O_MRD);
    step("lw2_memwb",     0, 6'h23, 0, 1, 4, O_MWB);

    // Reset while SW completes in MEMWR: write strobe suppressed
    step("sw_fetch",      0, 6'h2b, 0, 1, 0, O_FETCH);
    step("sw_dec",        0, 6'h2b, 0, 1, 1, O_DEC);
    step("sw_madr",       0, 6'h2b, 0, 1, 2, O_MADR);
    step("rst_in_memwr",  1, 6'h2b, 0, 1, 5, O_ZERO);
    step("fetch_wait",    0, 6'h2b, 0, 0, 0, O_FETCH_W);

    // Reset in a taken BEQ: pc_write suppressed
    step("beq_fetch",     0, 6'h04, 1, 1, 0, O_FETCH);
    step("beq_dec",       0, 6'h04, 1, 1, 1, O_DEC);
    step("rst_in_branch", 1, 6'h04, 1, 1, 8, O_ZERO);
    step("fetch_final",   0, 6'h04, 1, 1, 0, O_FETCH);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
